hdr_fifo_scheduler: RTL
=======================

# hdr_fifo_scheduler

Packet-granular round-robin scheduler that drains N header queues (synchronous FIFOs with same-cycle read data) into one registered valid/ready stream for the memcached header handler. Each granted source is locked until its packet's last beat is popped, so packets from different sources never interleave. A beat watchdog bounds lock time against malformed packets.

## Interface
- N, 4: number of source FIFOs; must be ≥ 2.
- DW, 32: FIFO word width; bit DW-1 is the last-beat flag, bits DW-2:0 are payload.
- MAX_BEATS, 16: maximum beats per grant before a forced release.
- SW, $clog2(N): source index width (derived localparam).

Ports:
- clk  in  1  single clock; all logic rises on posedge.
- rst  in  1  synchronous, active-high reset. Source FIFOs are reset from the same net via rst_ = ~rst at the parent.
- fifo_empty  in  N  per-source empty flag.
- fifo_dout  in  N*DW  per-source read data; source i occupies bits [i*DW +: DW]. Valid in the same cycle as its rd_en.
- fifo_rd_en  out  N  per-source pop; combinational; at most one bit high.
- out_valid  out  1  output register holds a beat.
- out_ready  in  1  downstream accepts when out_valid & out_ready.
- out_data  out  DW-1  payload of the held beat.
- out_last  out  1  last beat of the packet (the source flag, or forced by the watchdog).
- out_src  out  SW  source index of the held beat.
- err  out  1  one-cycle pulse when the watchdog forces a release.

## Operation
- States:
  - IDLE: no grant.
  - BUSY: locked to the granted source g.
- IDLE:
  - If any fifo_empty bit is 0, select the first non-empty source searching from rr_ptr upward, modulo N.
  - Register it as g, clear beat_cnt, and go to BUSY.
  - Otherwise stay in IDLE.
  - fifo_rd_en = 0 throughout IDLE.
- BUSY:
  - pop = ~fifo_empty[g] & (~out_valid | out_ready).
  - fifo_rd_en[g] = pop.
  - On pop:
    - out_data ← fifo_dout[g][DW-2:0].
    - out_src ← g.
    - out_last ← flag | (beat_cnt == MAX_BEATS-1).
    - beat_cnt increments.
- Release: when a popped beat has out_last = 1:
  - rr_ptr ← (g+1) mod N.
  - Go to IDLE.
  - err = 1 for that cycle if the release was forced and the flag was 0.
- Source empty mid-packet: stay in BUSY, no pop, no timeout. The watchdog counts beats, not cycles.
- Output register:
  - out_valid sets on pop.
  - out_valid clears on out_valid & out_ready without a pop.
  - out_valid holds otherwise.
  - out_data, out_last and out_src are stable while out_valid & ~out_ready.
- beat_cnt width: $clog2(MAX_BEATS+1). It never exceeds MAX_BEATS-1 at compare time.

## Timing
- Reset values:
  - state IDLE, rr_ptr 0, g 0, beat_cnt 0.
  - out_valid 0, out_data 0, out_last 0, out_src 0, err 0.
  - fifo_rd_en 0.
- Reset mid-packet: the packet is abandoned. The parent's FIFOs reset on the same edge, so no stale beats survive.
- Latency: source becomes non-empty in cycle t while in IDLE → BUSY at t+1 → first pop at t+1 → out_valid at t+2.
- Throughput:
  - Back-to-back output with out_ready held high: one beat per cycle inside a packet.
  - One IDLE bubble cycle between packets; an L-beat packet costs L+1 cycles.
- Backpressure: with out_valid & ~out_ready, no pop occurs and the FIFO pointer does not advance.
- Simultaneous pop and downstream accept: the new beat replaces the old one, and out_valid stays 1.
- Fairness: a source waits at most N-1 packets after becoming non-empty.

## Structure
- Shared package hdr_sched_pkg holds:
  - state enum {IDLE, BUSY};
  - LAST_BIT = DW-1 convention;
  - default N, DW, MAX_BEATS.
- Sub-module rr_pick: purely combinational rotate-priority picker.
  - Inputs: req[N], ptr[SW].
  - Outputs: gnt_idx[SW], gnt_any.
  - Instanced once in IDLE.
- Top level: FSM, beat counter, output register, read-enable decode. Target 150–250 lines.

## Test plan
- Single packet: source 2 holds 3 beats (flag on beat 3), out_ready = 1 → out_valid on 3 consecutive cycles starting 2 cycles after empty deasserts; out_src = 2; out_last only on beat 3; next state IDLE.
- Round-robin: sources 0, 1 and 3 each hold one 2-beat packet, issued together after reset → output order 0, 1, 3; one bubble between packets; rr_ptr ends at 0.
- Backpressure: out_ready = 0 for 5 cycles mid-packet → out_data/out_last/out_src frozen; fifo_rd_en = 0 during the stall; no beat lost or duplicated after release.
- Watchdog: source 1 streams 20 beats with no flag, MAX_BEATS = 16 → beat 16 has out_last = 1 and err pulses once; the scheduler re-arbitrates and source 1 is granted again if it is the only requester.
- Starved mid-packet: source 0 empties after beat 1 of 3 while source 1 has data → grant stays on 0 and no beats from 1 appear until 0's last beat.
- Reset mid-packet: assert rst during beat 2 of 4 → next cycle out_valid = 0, state IDLE, rr_ptr = 0, fifo_rd_en = 0.

Source files
------------

// File: rtl/hdr_sched_pkg.sv
// Shared definitions for the header FIFO scheduler.
// Holds the scheduler state encoding, the default parameter values and the
// helper that locates the last-beat flag inside a FIFO word.
package hdr_sched_pkg;

  localparam int DEF_N         = 4;
  localparam int DEF_DW        = 32;
  localparam int DEF_MAX_BEATS = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // The top bit of every FIFO word marks the final beat of a packet.
  function automatic int last_bit(input int dw);
    return dw - 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker.
// Returns the first asserted request found when searching upward from ptr,
// wrapping modulo N.
//   req     : per-source request vector
//   ptr     : source index that has highest priority this cycle
//   gnt_idx : index of the selected source (0 when nothing is requested)
//   gnt_any : at least one request is asserted
module rr_pick
  import hdr_sched_pkg::*;
#(
  parameter  int N  = DEF_N,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] gnt_idx,
  output logic          gnt_any
);

  logic [SW-1:0] idx;

  // Walk the offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = SW'((int'(ptr) + i) % N);
      if (req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/hdr_fifo_scheduler.sv
// Packet-granular round-robin scheduler draining N header FIFOs into one
// registered valid/ready stream. A granted source stays locked until its
// packet's last beat is popped; a beat watchdog forces a release after
// MAX_BEATS beats and pulses err.
//   clk, rst    : clock, synchronous active-high reset
//   fifo_empty  : per-source empty flags
//   fifo_dout   : per-source read data, source i at [i*DW +: DW], same-cycle
//   fifo_rd_en  : per-source pop (combinational, one-hot or zero)
//   out_valid   : output register holds a beat
//   out_ready   : downstream accept
//   out_data    : payload of the held beat
//   out_last    : held beat ends the packet (flag or watchdog)
//   out_src     : source index of the held beat
//   err         : one-cycle pulse accompanying a watchdog-forced last beat
module hdr_fifo_scheduler
  import hdr_sched_pkg::*;
#(
  parameter  int N         = DEF_N,
  parameter  int DW        = DEF_DW,
  parameter  int MAX_BEATS = DEF_MAX_BEATS,
  localparam int SW        = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  fifo_empty,
  input  logic [N*DW-1:0] fifo_dout,
  output logic [N-1:0]  fifo_rd_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-2:0] out_data,
  output logic          out_last,
  output logic [SW-1:0] out_src,
  output logic          err
);

  localparam int CW       = $clog2(MAX_BEATS + 1);
  localparam int LAST_BIT = last_bit(DW);

  state_e        state_q;
  logic [SW-1:0] g_q;
  logic [SW-1:0] rr_ptr_q;
  logic [CW-1:0] beat_cnt_q;
  logic          out_valid_q;
  logic [DW-2:0] out_data_q;
  logic          out_last_q;
  logic [SW-1:0] out_src_q;
  logic          err_q;

  logic [DW-1:0] dout_a [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign dout_a[i] = fifo_dout[i*DW +: DW];
  end

  logic [SW-1:0] pick_idx_d;
  logic          pick_any_d;

  rr_pick #(.N(N)) u_pick (
    .req     (~fifo_empty),
    .ptr     (rr_ptr_q),
    .gnt_idx (pick_idx_d),
    .gnt_any (pick_any_d)
  );

  logic [DW-1:0] head_d;
  logic          pop_d;
  logic          flag_d;
  logic          forced_d;
  logic          last_d;
  logic [SW-1:0] g_next_d;

  // Pop only when the output register is free or being drained this cycle.
  // Reset gates the pop so the FIFOs never see a read on the reset edge.
  always_comb begin
    head_d     = dout_a[g_q];
    flag_d     = head_d[LAST_BIT];
    pop_d      = ~rst & (state_q == BUSY) & ~fifo_empty[g_q]
                 & (~out_valid_q | out_ready);
    forced_d   = (beat_cnt_q == CW'(MAX_BEATS - 1));
    last_d     = flag_d | forced_d;
    g_next_d   = (g_q == SW'(N - 1)) ? '0 : g_q + 1'b1;
    fifo_rd_en = '0;
    fifo_rd_en[g_q] = pop_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      g_q         <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;

      // A pop overwrites the held beat even when it is being accepted now.
      if (pop_d) begin
        out_valid_q <= 1'b1;
        out_data_q  <= head_d[DW-2:0];
        out_last_q  <= last_d;
        out_src_q   <= g_q;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (pick_any_d) begin
            g_q        <= pick_idx_d;
            beat_cnt_q <= '0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          // An empty source just stalls here; the watchdog counts beats only.
          if (pop_d) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (last_d) begin
              rr_ptr_q <= g_next_d;
              state_q  <= IDLE;
              err_q    <= ~flag_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;
  assign err       = err_q;

endmodule
